// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit.
//
// Sequences each instruction through FETCH/DECODE and an opcode-specific
// execute path, producing datapath controls as combinational functions of
// the current state and the instruction fields.
//
// Ports:
//   clk        - clock, all state changes on rising edge
//   rst_n      - asynchronous active-low reset
//   Op, Funct  - opcode and R-type function field from the instruction register
//   Zero       - ALU zero flag, used for beq/bne
//   MemReady   - memory access completes this cycle
//   IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
//   AluSrcA, PCEn, ExtOp        - single-bit datapath controls
//   AluSrcB    - 00 B, 01 const 4, 10 ext imm, 11 ext imm << 2
//   PCSrc      - 00 ALU result, 01 ALUOut, 10 jump target
//   AluCtl     - 010 add, 110 sub, 000 and, 001 or, 111 slt
//   IllegalOp  - one-cycle pulse when DECODE sees an unsupported opcode
//   State      - current state code, for debug
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic       PCEn,
  output logic       ExtOp,
  output logic [1:0] AluSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] AluCtl,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    IMMEX  = 4'd9,
    IMMWB  = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state;
  state_t next_state;

  // Ungated versions of the enables that must be forced low during reset.
  logic mem_read_c;
  logic mem_write_c;
  logic ir_write_c;
  logic reg_write_c;
  logic pc_en_c;
  logic illegal_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = FETCH;
    IorD        = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    reg_write_c = 1'b0;
    AluSrcA     = 1'b0;
    pc_en_c     = 1'b0;
    ExtOp       = 1'b0;
    AluSrcB     = 2'b00;
    PCSrc       = 2'b00;
    AluCtl      = ALU_ADD;
    illegal_c   = 1'b0;

    case (state)
      FETCH: begin
        mem_read_c = 1'b1;
        AluSrcB    = 2'b01;
        // PC+4 and the instruction latch only commit once memory delivers.
        if (MemReady) begin
          ir_write_c = 1'b1;
          pc_en_c    = 1'b1;
          next_state = DECODE;
        end else begin
          next_state = FETCH;
        end
      end

      DECODE: begin
        // Branch target is computed here speculatively into ALUOut.
        AluSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW:               next_state = MEMADR;
          OP_RTYPE:                   next_state = EXEC;
          OP_BEQ, OP_BNE:             next_state = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:   next_state = IMMEX;
          OP_J:                       next_state = JUMP;
          default: begin
            next_state = FETCH;
            illegal_c  = 1'b1;
          end
        endcase
      end

      MEMADR: begin
        AluSrcA    = 1'b1;
        AluSrcB    = 2'b10;
        ExtOp      = 1'b1;
        next_state = (Op == OP_LW) ? MEMRD : MEMWR;
      end

      MEMRD: begin
        IorD       = 1'b1;
        mem_read_c = 1'b1;
        next_state = MemReady ? MEMWB : MEMRD;
      end

      MEMWB: begin
        MemToReg    = 1'b1;
        reg_write_c = 1'b1;
        next_state  = FETCH;
      end

      MEMWR: begin
        IorD        = 1'b1;
        mem_write_c = 1'b1;
        next_state  = MemReady ? FETCH : MEMWR;
      end

      EXEC: begin
        AluSrcA = 1'b1;
        case (Funct)
          6'b100000: AluCtl = ALU_ADD;
          6'b100010: AluCtl = ALU_SUB;
          6'b100100: AluCtl = ALU_AND;
          6'b100101: AluCtl = ALU_OR;
          6'b101010: AluCtl = ALU_SLT;
          default:   AluCtl = ALU_ADD;
        endcase
        next_state = ALUWB;
      end

      ALUWB: begin
        RegDst      = 1'b1;
        reg_write_c = 1'b1;
        next_state  = FETCH;
      end

      BRANCH: begin
        AluSrcA    = 1'b1;
        AluCtl     = ALU_SUB;
        PCSrc      = 2'b01;
        pc_en_c    = ((Op == OP_BEQ) && Zero) || ((Op == OP_BNE) && !Zero);
        next_state = FETCH;
      end

      IMMEX: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        // Logical immediates are zero-extended, arithmetic ones sign-extended.
        case (Op)
          OP_ANDI: AluCtl = ALU_AND;
          OP_ORI:  AluCtl = ALU_OR;
          default: begin
            AluCtl = ALU_ADD;
            ExtOp  = 1'b1;
          end
        endcase
        next_state = IMMWB;
      end

      IMMWB: begin
        reg_write_c = 1'b1;
        next_state  = FETCH;
      end

      JUMP: begin
        PCSrc      = 2'b10;
        pc_en_c    = 1'b1;
        next_state = FETCH;
      end

      default: next_state = FETCH;
    endcase
  end

  // The state register is already FETCH while rst_n is low, but FETCH would
  // still request a read; gating with rst_n makes reset kill every enable
  // combinationally, so no write can complete after rst_n falls.
  assign MemRead   = mem_read_c  & rst_n;
  assign MemWrite  = mem_write_c & rst_n;
  assign IRWrite   = ir_write_c  & rst_n;
  assign RegWrite  = reg_write_c & rst_n;
  assign PCEn      = pc_en_c     & rst_n;
  assign IllegalOp = illegal_c   & rst_n;
  assign State     = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle vector table of
// inputs and expected state/controls, plus reset-during-wait sequences.
module tb_multicycle_controller;

  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk;
  logic       rst_n;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite;
  logic       AluSrcA, PCEn, ExtOp, IllegalOp;
  logic [1:0] AluSrcB, PCSrc;
  logic [2:0] AluCtl;
  logic [3:0] State;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .AluSrcA(AluSrcA), .PCEn(PCEn), .ExtOp(ExtOp),
    .AluSrcB(AluSrcB), .PCSrc(PCSrc), .AluCtl(AluCtl),
    .IllegalOp(IllegalOp), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order:
  // IorD MemRead MemWrite IRWrite RegDst MemToReg RegWrite AluSrcA PCEn ExtOp
  // AluSrcB[1:0] PCSrc[1:0] AluCtl[2:0] IllegalOp
  logic [17:0] act_ctl;
  assign act_ctl = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
                    RegWrite, AluSrcA, PCEn, ExtOp, AluSrcB, PCSrc, AluCtl,
                    IllegalOp};

  function automatic logic [17:0] c(
    input logic iord, input logic mr, input logic mw, input logic irw,
    input logic rd, input logic m2r, input logic rw, input logic asa,
    input logic pcen, input logic ext, input logic [1:0] asb,
    input logic [1:0] pcs, input logic [2:0] alu, input logic ill);
    return {iord, mr, mw, irw, rd, m2r, rw, asa, pcen, ext, asb, pcs, alu, ill};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] ctl;
  } vec_t;

  vec_t vecs[$];

  logic [17:0] c_reset, c_fetch_rdy, c_fetch_wait, c_decode, c_decode_ill;
  logic [17:0] c_memadr, c_memrd, c_memwb, c_memwr, c_aluwb;
  logic [17:0] c_br_taken, c_br_not, c_addi, c_andi, c_ori, c_immwb, c_jump;

  task automatic add(input logic [5:0] op, input logic [5:0] funct,
                     input logic zero, input logic mr, input logic [3:0] st,
                     input logic [17:0] ctl);
    vec_t v;
    v.op = op; v.funct = funct; v.zero = zero; v.mr = mr; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                               input logic zero, input logic mr);
    Op = op; Funct = funct; Zero = zero; MemReady = mr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] est,
                             input logic [17:0] ectl);
    n_checks++;
    if (State !== est) begin
      n_fail++;
      $display("[TB] FAIL %s state: got %0d expected %0d", name, State, est);
    end
    n_checks++;
    if (act_ctl !== ectl) begin
      n_fail++;
      $display("[TB] FAIL %s controls: got %b expected %b", name, act_ctl, ectl);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    c_reset      = c(0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0);
    c_fetch_rdy  = c(0,1,0,1,0,0,0,0,1,0,2'b01,2'b00,3'b010,0);
    c_fetch_wait = c(0,1,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0);
    c_decode     = c(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0);
    c_decode_ill = c(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1);
    c_memadr     = c(0,0,0,0,0,0,0,1,0,1,2'b10,2'b00,3'b010,0);
    c_memrd      = c(1,1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,0);
    c_memwb      = c(0,0,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b010,0);
    c_memwr      = c(1,0,1,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,0);
    c_aluwb      = c(0,0,0,0,1,0,1,0,0,0,2'b00,2'b00,3'b010,0);
    c_br_taken   = c(0,0,0,0,0,0,0,1,1,0,2'b00,2'b01,3'b110,0);
    c_br_not     = c(0,0,0,0,0,0,0,1,0,0,2'b00,2'b01,3'b110,0);
    c_addi       = c(0,0,0,0,0,0,0,1,0,1,2'b10,2'b00,3'b010,0);
    c_andi       = c(0,0,0,0,0,0,0,1,0,0,2'b10,2'b00,3'b000,0);
    c_ori        = c(0,0,0,0,0,0,0,1,0,0,2'b10,2'b00,3'b001,0);
    c_immwb      = c(0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,0);
    c_jump       = c(0,0,0,0,0,0,0,0,1,0,2'b00,2'b10,3'b010,0);

    // lw, no waits: 0,1,2,3,4
    add(OP_LW, 6'd0, 0, 1, 4'd0, c_fetch_rdy);
    add(OP_LW, 6'd0, 0, 1, 4'd1, c_decode);
    add(OP_LW, 6'd0, 0, 1, 4'd2, c_memadr);
    add(OP_LW, 6'd0, 0, 1, 4'd3, c_memrd);
    add(OP_LW, 6'd0, 0, 1, 4'd4, c_memwb);
    // sw with one fetch wait and three MEMWR waits
    add(OP_SW, 6'd0, 0, 0, 4'd0, c_fetch_wait);
    add(OP_SW, 6'd0, 0, 1, 4'd0, c_fetch_rdy);
    add(OP_SW, 6'd0, 0, 1, 4'd1, c_decode);
    add(OP_SW, 6'd0, 0, 1, 4'd2, c_memadr);
    for (int i = 0; i < 3; i++) add(OP_SW, 6'd0, 0, 0, 4'd5, c_memwr);
    add(OP_SW, 6'd0, 0, 1, 4'd5, c_memwr);
    // beq/bne with both Zero values
    for (int b = 0; b < 4; b++) begin
      logic [5:0] bop;
      logic       z;
      logic       taken;
      bop   = (b < 2) ? OP_BEQ : OP_BNE;
      z     = (b % 2 == 0);
      taken = (b == 0) || (b == 3);
      add(bop, 6'd0, z, 1, 4'd0, c_fetch_rdy);
      add(bop, 6'd0, z, 1, 4'd1, c_decode);
      add(bop, 6'd0, z, 1, 4'd8, taken ? c_br_taken : c_br_not);
    end
    // R-type over all function codes plus an unknown one
    begin
      logic [5:0] fn [6];
      logic [2:0] al [6];
      fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      al = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
      for (int i = 0; i < 6; i++) begin
        add(OP_RT, fn[i], 0, 1, 4'd0, c_fetch_rdy);
        add(OP_RT, fn[i], 0, 1, 4'd1, c_decode);
        add(OP_RT, fn[i], 0, 1, 4'd6,
            c(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,al[i],0));
        add(OP_RT, fn[i], 0, 1, 4'd7, c_aluwb);
      end
    end
    // immediates
    add(OP_ADDI, 6'd0, 0, 1, 4'd0, c_fetch_rdy);
    add(OP_ADDI, 6'd0, 0, 1, 4'd1, c_decode);
    add(OP_ADDI, 6'd0, 0, 1, 4'd9, c_addi);
    add(OP_ADDI, 6'd0, 0, 1, 4'd10, c_immwb);
    add(OP_ANDI, 6'd0, 0, 1, 4'd0, c_fetch_rdy);
    add(OP_ANDI, 6'd0, 0, 1, 4'd1, c_decode);
    add(OP_ANDI, 6'd0, 0, 1, 4'd9, c_andi);
    add(OP_ANDI, 6'd0, 0, 1, 4'd10, c_immwb);
    add(OP_ORI, 6'd0, 0, 1, 4'd0, c_fetch_rdy);
    add(OP_ORI, 6'd0, 0, 1, 4'd1, c_decode);
    add(OP_ORI, 6'd0, 0, 1, 4'd9, c_ori);
    add(OP_ORI, 6'd0, 0, 1, 4'd10, c_immwb);
    // jump
    add(OP_J, 6'd0, 0, 1, 4'd0, c_fetch_rdy);
    add(OP_J, 6'd0, 0, 1, 4'd1, c_decode);
    add(OP_J, 6'd0, 0, 1, 4'd11, c_jump);
    // illegal opcode: 0,1,0 with one IllegalOp pulse
    add(OP_BAD, 6'd0, 0, 1, 4'd0, c_fetch_rdy);
    add(OP_BAD, 6'd0, 0, 1, 4'd1, c_decode_ill);
    add(OP_BAD, 6'd0, 0, 0, 4'd0, c_fetch_wait);

    // Reset state with MemReady high: enables forced low.
    rst_n = 1'b0;
    applyStimulus(OP_LW, 6'd0, 0, 1);
    #12;
    checkOutput("reset", 4'd0, c_reset);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].mr);
      checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctl);
      step();
    end

    // Reset during a MEMRD wait.
    applyStimulus(OP_LW, 6'd0, 0, 1);
    checkOutput("rdwait_fetch", 4'd0, c_fetch_rdy);
    step();
    step();
    step();
    applyStimulus(OP_LW, 6'd0, 0, 0);
    checkOutput("rdwait_memrd", 4'd3, c_memrd);
    step();
    #1;
    checkOutput("rdwait_hold", 4'd3, c_memrd);
    rst_n = 1'b0;
    #1;
    checkOutput("rdwait_reset", 4'd0, c_reset);
    #2;
    rst_n = 1'b1;
    step();
    checkOutput("rdwait_restart", 4'd0, c_fetch_wait);

    // Reset during a MEMWR wait must drop MemWrite at once.
    applyStimulus(OP_SW, 6'd0, 0, 1);
    step();
    step();
    step();
    applyStimulus(OP_SW, 6'd0, 0, 0);
    checkOutput("wrwait_memwr", 4'd5, c_memwr);
    rst_n = 1'b0;
    #1;
    checkOutput("wrwait_reset", 4'd0, c_reset);
    #2;
    rst_n = 1'b1;
    step();
    checkOutput("wrwait_restart", 4'd0, c_fetch_wait);
    applyStimulus(OP_J, 6'd0, 0, 1);
    checkOutput("wrwait_fetch", 4'd0, c_fetch_rdy);
    step();
    checkOutput("wrwait_decode", 4'd1, c_decode);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
